// File: rtl/fann_wb_pkg.sv
// Register map, control/status bit positions and FSM encoding shared by the
// Fast-ANN Wishbone loader and its stream slots.
package fann_wb_pkg;

    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h04;
    localparam logic [7:0] OFF_PUSH_BASE = 8'h10;
    localparam logic [7:0] OFF_POP       = 8'h30;
    localparam logic [7:0] OFF_CNT_BASE  = 8'h40;

    localparam int CTRL_START       = 0;
    localparam int CTRL_SEND_BEST   = 1;
    localparam int CTRL_LOAD_KDTREE = 2;
    localparam int CTRL_IRQ_EN      = 3;
    localparam int CTRL_CLR_DONE    = 5;
    localparam int CTRL_CLR_CNT     = 6;
    localparam int CTRL_CLR_ERR     = 7;

    localparam int STAT_DONE         = 0;
    localparam int STAT_ERR_TIMEOUT  = 1;
    localparam int STAT_ERR_SEL      = 2;
    localparam int STAT_DONE_LATCHED = 3;
    localparam int STAT_CH_VALID     = 8;
    localparam int STAT_RES_VALID    = 15;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    function automatic int lane_count(input int data_width);
        return 32 / data_width;
    endfunction

endpackage

// File: rtl/fann_wb_stream_slot.sv
// One-entry valid/ready holding buffer; accept_o tells the bus side whether a
// push this cycle can be taken (slot empty or being drained right now).
module wb_stream_slot
    import fann_wb_pkg::*;
#(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             accept_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign accept_o = ~valid_q | ready_i;
    assign valid_o  = valid_q;
    assign data_o   = data_q;

    // A push while draining reloads the slot so valid never bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push_i && accept_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fann_wb_loader.sv
// Wishbone-classic slave bridging the Caravel management bus to the Fast-ANN
// accelerator: per-channel push slots, result pop, control and status registers.
module fann_wb_loader
    import fann_wb_pkg::*;
#(
    parameter int          DATA_WIDTH = 11,
    parameter int          NUM_CH     = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          TIMEOUT    = 1024,
    localparam int         LANES      = lane_count(DATA_WIDTH)
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    input  logic                               wbs_stb_i,
    input  logic                               wbs_cyc_i,
    input  logic                               wbs_we_i,
    input  logic [3:0]                         wbs_sel_i,
    input  logic [31:0]                        wbs_adr_i,
    input  logic [31:0]                        wbs_dat_i,
    output logic                               wbs_ack_o,
    output logic [31:0]                        wbs_dat_o,
    output logic [NUM_CH-1:0]                  ch_valid_o,
    output logic [NUM_CH*LANES*DATA_WIDTH-1:0] ch_data_o,
    input  logic [NUM_CH-1:0]                  ch_ready_i,
    input  logic                               res_valid_i,
    input  logic [DATA_WIDTH-1:0]              res_data_i,
    output logic                               res_ready_o,
    output logic                               fsm_start_o,
    output logic                               send_best_arr_o,
    output logic                               load_kdtree_o,
    input  logic                               fsm_done_i,
    output logic                               irq_o
);

    localparam int SW = LANES * DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          res_ready_q, res_ready_d;
    logic          start_q, start_d;
    logic          send_best_q, send_best_d;
    logic          load_kdtree_q, load_kdtree_d;
    logic          irq_en_q, irq_en_d;
    logic          done_prev_q, done_prev_d;
    logic          done_latched_q, done_latched_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_sel_q, err_sel_d;
    logic [15:0]   cnt_q [NUM_CH];
    logic [15:0]   cnt_d [NUM_CH];

    logic [NUM_CH-1:0] slot_accept, slot_valid, slot_push;
    logic [NUM_CH-1:0] push_sel, cnt_sel;
    logic [7:0]        off;
    logic [31:0]       status_word, cnt_word, rdata;
    logic              hit, sel_ok, is_ctrl, is_status, is_pop, is_push, stall;
    logic              service, timeout;
    logic              unused_bits;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        wb_stream_slot #(.WIDTH(SW)) u_slot (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .push_i   (slot_push[c]),
            .data_i   (wbs_dat_i[SW-1:0]),
            .ready_i  (ch_ready_i[c]),
            .accept_o (slot_accept[c]),
            .valid_o  (slot_valid[c]),
            .data_o   (ch_data_o[c*SW +: SW])
        );
    end

    // Address decode, stall detection and the read-data mux.
    always_comb begin
        hit         = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        off         = {wbs_adr_i[7:2], 2'b00};
        sel_ok      = (wbs_sel_i == 4'hF);
        is_ctrl     = (off == OFF_CTRL);
        is_status   = (off == OFF_STATUS);
        is_pop      = (off == OFF_POP) & ~wbs_we_i;
        push_sel    = '0;
        cnt_sel     = '0;
        cnt_word    = '0;
        status_word = '0;
        status_word[STAT_DONE]         = fsm_done_i;
        status_word[STAT_ERR_TIMEOUT]  = err_timeout_q;
        status_word[STAT_ERR_SEL]      = err_sel_q;
        status_word[STAT_DONE_LATCHED] = done_latched_q;
        status_word[STAT_RES_VALID]    = res_valid_i;
        for (int c = 0; c < NUM_CH; c++) begin
            push_sel[c] = (off == OFF_PUSH_BASE + 8'(4 * c));
            cnt_sel[c]  = (off == OFF_CNT_BASE + 8'(4 * c));
            status_word[STAT_CH_VALID + c] = slot_valid[c];
            if (cnt_sel[c]) begin
                cnt_word = {16'h0000, cnt_q[c]};
            end
        end
        is_push = (|push_sel) & wbs_we_i;
        stall   = (is_push & sel_ok & ~|(push_sel & slot_accept)) |
                  (is_pop & ~res_valid_i);

        rdata = '0;
        if (is_ctrl) begin
            rdata[CTRL_LOAD_KDTREE] = load_kdtree_q;
            rdata[CTRL_IRQ_EN]      = irq_en_q;
        end else if (is_status) begin
            rdata = status_word;
        end else if (is_pop) begin
            rdata = 32'(res_data_i);
        end else if (|cnt_sel) begin
            rdata = cnt_word;
        end
    end

    // Bus FSM plus the register side effects of a serviced or timed-out access.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        ack_d          = 1'b0;
        dat_d          = dat_q;
        res_ready_d    = 1'b0;
        start_d        = 1'b0;
        send_best_d    = 1'b0;
        load_kdtree_d  = load_kdtree_q;
        irq_en_d       = irq_en_q;
        done_prev_d    = fsm_done_i;
        done_latched_d = done_latched_q;
        err_timeout_d  = err_timeout_q;
        err_sel_d      = err_sel_q;
        slot_push      = '0;
        service        = 1'b0;
        timeout        = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
        end

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (stall) begin
                        state_d = WAIT;
                        wait_d  = TW'(1);
                    end else begin
                        service = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!hit) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    service = 1'b1;
                end else if (wait_q == TW'(TIMEOUT)) begin
                    timeout = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (service || timeout) begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (!wbs_we_i) begin
                dat_d = rdata;
            end
        end

        if (timeout) begin
            err_timeout_d = 1'b1;
            if (is_pop) begin
                dat_d = 32'hFFFF_FFFF;
            end
        end

        if (service) begin
            if (is_push) begin
                if (sel_ok) begin
                    slot_push = push_sel;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (push_sel[c]) begin
                            cnt_d[c] = cnt_q[c] + 16'd1;
                        end
                    end
                end else begin
                    err_sel_d = 1'b1;
                end
            end
            if (is_pop) begin
                res_ready_d = 1'b1;
            end
            if (is_ctrl && wbs_we_i) begin
                start_d       = wbs_dat_i[CTRL_START];
                send_best_d   = wbs_dat_i[CTRL_SEND_BEST];
                load_kdtree_d = wbs_dat_i[CTRL_LOAD_KDTREE];
                irq_en_d      = wbs_dat_i[CTRL_IRQ_EN];
                if (wbs_dat_i[CTRL_CLR_DONE]) begin
                    done_latched_d = 1'b0;
                end
                if (wbs_dat_i[CTRL_CLR_CNT]) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        cnt_d[c] = '0;
                    end
                end
                if (wbs_dat_i[CTRL_CLR_ERR]) begin
                    err_timeout_d = 1'b0;
                    err_sel_d     = 1'b0;
                end
            end
        end

        // A done edge coinciding with a clear must not be lost.
        if (fsm_done_i && !done_prev_q) begin
            done_latched_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            ack_q          <= 1'b0;
            dat_q          <= '0;
            res_ready_q    <= 1'b0;
            start_q        <= 1'b0;
            send_best_q    <= 1'b0;
            load_kdtree_q  <= 1'b0;
            irq_en_q       <= 1'b0;
            done_prev_q    <= 1'b0;
            done_latched_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_sel_q      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            ack_q          <= ack_d;
            dat_q          <= dat_d;
            res_ready_q    <= res_ready_d;
            start_q        <= start_d;
            send_best_q    <= send_best_d;
            load_kdtree_q  <= load_kdtree_d;
            irq_en_q       <= irq_en_d;
            done_prev_q    <= done_prev_d;
            done_latched_q <= done_latched_d;
            err_timeout_q  <= err_timeout_d;
            err_sel_q      <= err_sel_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign wbs_ack_o       = ack_q;
    assign wbs_dat_o       = dat_q;
    assign ch_valid_o      = slot_valid;
    assign res_ready_o     = res_ready_q;
    assign fsm_start_o     = start_q;
    assign send_best_arr_o = send_best_q;
    assign load_kdtree_o   = load_kdtree_q;
    assign irq_o           = irq_en_q & done_latched_q;

endmodule

// File: tb/tb_fann_wb_loader.sv
// Directed bench for fann_wb_loader with TIMEOUT shortened to 16 cycles so
// stall and timeout paths finish quickly.
module tb_fann_wb_loader;

    localparam int          DATA_WIDTH = 11;
    localparam int          NUM_CH     = 3;
    localparam int          LANES      = 2;
    localparam int          TIMEOUT    = 16;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    logic                               wb_clk_i = 1'b0;
    logic                               wb_rst_i;
    logic                               wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]                         wbs_sel_i;
    logic [31:0]                        wbs_adr_i, wbs_dat_i;
    logic                               wbs_ack_o;
    logic [31:0]                        wbs_dat_o;
    logic [NUM_CH-1:0]                  ch_valid_o;
    logic [NUM_CH*LANES*DATA_WIDTH-1:0] ch_data_o;
    logic [NUM_CH-1:0]                  ch_ready_i;
    logic                               res_valid_i;
    logic [DATA_WIDTH-1:0]              res_data_i;
    logic                               res_ready_o;
    logic                               fsm_start_o, send_best_arr_o, load_kdtree_o;
    logic                               fsm_done_i;
    logic                               irq_o;

    int          checks = 0;
    int          errors = 0;
    int          latency;
    int          ackCount;
    logic [31:0] readData;

    fann_wb_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CH     (NUM_CH),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .wbs_stb_i       (wbs_stb_i),
        .wbs_cyc_i       (wbs_cyc_i),
        .wbs_we_i        (wbs_we_i),
        .wbs_sel_i       (wbs_sel_i),
        .wbs_adr_i       (wbs_adr_i),
        .wbs_dat_i       (wbs_dat_i),
        .wbs_ack_o       (wbs_ack_o),
        .wbs_dat_o       (wbs_dat_o),
        .ch_valid_o      (ch_valid_o),
        .ch_data_o       (ch_data_o),
        .ch_ready_i      (ch_ready_i),
        .res_valid_i     (res_valid_i),
        .res_data_i      (res_data_i),
        .res_ready_o     (res_ready_o),
        .fsm_start_o     (fsm_start_o),
        .send_best_arr_o (send_best_arr_o),
        .load_kdtree_o   (load_kdtree_o),
        .fsm_done_i      (fsm_done_i),
        .irq_o           (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One bus transfer starting in an idle cycle; returns cycles-to-ack (-1 if none).
    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                                 input logic we, input logic [3:0] sel,
                                 output int lat, output logic [31:0] rdat);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                lat = i;
                break;
            end
        end
        rdat      = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        wbs_stb_i   = 1'b0;
        wbs_cyc_i   = 1'b0;
        wbs_we_i    = 1'b0;
        wbs_sel_i   = 4'h0;
        wbs_adr_i   = '0;
        wbs_dat_i   = '0;
        ch_ready_i  = '0;
        res_valid_i = 1'b0;
        res_data_i  = '0;
        fsm_done_i  = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("reset_ack", 32'(wbs_ack_o), 32'h0);
        checkOutput("reset_dat", wbs_dat_o, 32'h0);
        checkOutput("reset_valid", 32'(ch_valid_o), 32'h0);
        checkOutput("reset_pulses", 32'({fsm_start_o, send_best_arr_o, load_kdtree_o,
                                          irq_o, res_ready_o}), 32'h0);
        wb_rst_i = 1'b0;

        $display("[TB] basic push");
        applyStimulus(BASE + 32'h10, 32'h0001_B801, 1'b1, 4'hF, latency, readData);
        checkOutput("push_latency", 32'(latency), 32'd1);
        checkOutput("push_valid", 32'(ch_valid_o), 32'h1);
        checkOutput("push_lane0", 32'(ch_data_o[10:0]), 32'd1);
        checkOutput("push_lane1", 32'(ch_data_o[21:11]), 32'd55);
        @(posedge wb_clk_i);
        #1;
        checkOutput("ack_one_cycle", 32'(wbs_ack_o), 32'h0);
        applyStimulus(BASE + 32'h40, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("count0_one", readData, 32'd1);

        $display("[TB] stalled push released by ready");
        fork
            applyStimulus(BASE + 32'h10, 32'h0000_0802, 1'b1, 4'hF, latency, readData);
            begin
                wait (wbs_cyc_i === 1'b1);
                repeat (10) @(posedge wb_clk_i);
                #2 ch_ready_i[0] = 1'b1;
            end
        join
        ch_ready_i[0] = 1'b0;
        checkOutput("stall_latency", 32'(latency), 32'd11);
        checkOutput("stall_valid", 32'(ch_valid_o), 32'h1);
        checkOutput("stall_data", 32'(ch_data_o[21:0]), 32'h0000_0802);
        applyStimulus(BASE + 32'h40, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("count0_two", readData, 32'd2);
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_no_err", readData, 32'h0000_0100);

        $display("[TB] push timeout");
        applyStimulus(BASE + 32'h10, 32'h0000_0003, 1'b1, 4'hF, latency, readData);
        checkOutput("timeout_latency", 32'(latency), 32'(TIMEOUT + 1));
        checkOutput("timeout_data_kept", 32'(ch_data_o[21:0]), 32'h0000_0802);
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_timeout", readData, 32'h0000_0102);
        applyStimulus(BASE + 32'h40, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("count0_after_drop", readData, 32'd2);

        $display("[TB] control register");
        applyStimulus(BASE + 32'h00, 32'h0000_000D, 1'b1, 4'hF, latency, readData);
        checkOutput("start_pulse", 32'(fsm_start_o), 32'h1);
        checkOutput("load_level", 32'(load_kdtree_o), 32'h1);
        checkOutput("send_best_idle", 32'(send_best_arr_o), 32'h0);
        @(posedge wb_clk_i);
        #1;
        checkOutput("start_one_cycle", 32'(fsm_start_o), 32'h0);
        applyStimulus(BASE + 32'h00, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("ctrl_read", readData, 32'h0000_000C);
        @(negedge wb_clk_i);
        fsm_done_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        checkOutput("irq_set", 32'(irq_o), 32'h1);
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_done", readData, 32'h0000_010B);
        applyStimulus(BASE + 32'h00, 32'h0000_002C, 1'b1, 4'hF, latency, readData);
        checkOutput("irq_cleared", 32'(irq_o), 32'h0);
        applyStimulus(BASE + 32'h00, 32'h0000_000E, 1'b1, 4'hF, latency, readData);
        checkOutput("send_best_pulse", 32'({send_best_arr_o, fsm_start_o}), 32'h2);
        applyStimulus(BASE + 32'h00, 32'h0000_008C, 1'b1, 4'hF, latency, readData);
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_err_clear", readData, 32'h0000_0101);

        $display("[TB] result pop");
        @(negedge wb_clk_i);
        res_valid_i = 1'b1;
        res_data_i  = 11'd1234;
        applyStimulus(BASE + 32'h30, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("pop_latency", 32'(latency), 32'd1);
        checkOutput("pop_data", readData, 32'd1234);
        checkOutput("pop_ready_pulse", 32'(res_ready_o), 32'h1);
        @(posedge wb_clk_i);
        #1;
        checkOutput("pop_ready_once", 32'(res_ready_o), 32'h0);
        res_valid_i = 1'b0;
        applyStimulus(BASE + 32'h30, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("pop_timeout_latency", 32'(latency), 32'(TIMEOUT + 1));
        checkOutput("pop_timeout_data", readData, 32'hFFFF_FFFF);
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_pop_timeout", readData, 32'h0000_0103);

        $display("[TB] address miss and byte-select error");
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wbs_adr_i = 32'h3000_1000;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        ackCount  = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) ackCount++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        checkOutput("miss_no_ack", 32'(ackCount), 32'd0);
        checkOutput("miss_dat_hold", wbs_dat_o, 32'h0000_0103);
        applyStimulus(BASE + 32'h14, 32'h0000_0123, 1'b1, 4'h3, latency, readData);
        checkOutput("sel_latency", 32'(latency), 32'd1);
        checkOutput("sel_dropped", 32'(ch_valid_o), 32'h1);
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_sel_err", readData, 32'h0000_0107);
        applyStimulus(BASE + 32'h14, 32'h0000_0005, 1'b1, 4'hF, latency, readData);
        checkOutput("ch1_valid", 32'(ch_valid_o), 32'h3);
        checkOutput("ch1_data", 32'(ch_data_o[43:22]), 32'h0000_0005);
        applyStimulus(BASE + 32'h44, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("count1_one", readData, 32'd1);
        applyStimulus(BASE + 32'h00, 32'h0000_004C, 1'b1, 4'hF, latency, readData);
        applyStimulus(BASE + 32'h40, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("count0_cleared", readData, 32'd0);
        applyStimulus(BASE + 32'h80, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("unmapped_read", readData, 32'h0);
        applyStimulus(BASE + 32'h10, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("push_readback_zero", readData, 32'h0);

        $display("[TB] reset during stall");
        fsm_done_i = 1'b0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wbs_adr_i = BASE + 32'h10;
        wbs_dat_i = 32'h0000_0777;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        ackCount  = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) ackCount++;
        end
        @(negedge wb_clk_i);
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i);
        #1;
        checkOutput("stall_no_ack", 32'(ackCount), 32'd0);
        checkOutput("reset_mid_ack", 32'(wbs_ack_o), 32'h0);
        checkOutput("reset_mid_valid", 32'(ch_valid_o), 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        applyStimulus(BASE + 32'h04, 32'h0, 1'b0, 4'hF, latency, readData);
        checkOutput("status_after_reset", readData, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
